// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared types, constants and helpers for the FP32 divider front end
package fp_div_pkg;

  // Operand class after flush-to-zero; subnormals are reported as CLS_ZERO.
  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_cls_e;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;
  localparam int          FP_BIAS = 127;

  // Bit positions inside out_flags = {inv, dz, of, uf}.
  localparam int FLAG_INV = 3;
  localparam int FLAG_DZ  = 2;
  localparam int FLAG_OF  = 1;
  localparam int FLAG_UF  = 0;

  // Biased exponent of the quotient before rounding. A smaller dividend
  // mantissa means the significand ratio is below 1.0, costing one exponent.
  function automatic logic signed [9:0] pred_exp(input logic [31:0] a, input logic [31:0] b);
    logic signed [9:0] e;
    e = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + $signed(10'(FP_BIAS));
    if (a[22:0] < b[22:0]) begin
      e = e - 10'sd1;
    end
    return e;
  endfunction

endpackage

// File: rtl/fp_div_classify.sv
// rtl/fp_div_classify.sv - flush-to-zero and IEEE class for one FP32 operand
//
// Purely combinational.
// Ports:
//   op      in   32  raw FP32 operand
//   op_ftz  out  32  operand with subnormals replaced by a signed zero
//   cls     out   2  fp_cls_e class of op_ftz
module fp_div_classify
  import fp_div_pkg::*;
(
  input  logic [31:0] op,
  output logic [31:0] op_ftz,
  output logic [1:0]  cls
);

  fp_cls_e cls_e;

  always_comb begin
    op_ftz = op;
    cls_e  = CLS_NORM;
    if (op[30:23] == 8'h00) begin
      // Zero and subnormal alike: keep only the sign.
      op_ftz = {op[31], 31'b0};
      cls_e  = CLS_ZERO;
    end else if (op[30:23] == 8'hFF) begin
      cls_e = (op[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    end
  end

  assign cls = cls_e;

endmodule

// File: rtl/fp_div_frontend.sv
// rtl/fp_div_frontend.sv - two-stage valid/ready front end around a combinational FP32 divider
//
// Stage 1 registers the flushed operands (which feed the external divider
// directly), the tag, both classes and the predicted exponent. Stage 2
// registers either the divider quotient or a canonical special result plus
// the exception flags. Optional statistics counters exist only when
// FP_DIV_STATS_EN is defined.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          operand handshake
//   in_a, in_b, in_tag         dividend, divisor, opaque tag
//   div_a, div_b               stage-1 operands to the divider
//   div_q                      divider quotient (combinational from div_a/div_b)
//   out_valid/out_ready        result handshake
//   out_q, out_tag, out_flags  result, tag, {inv, dz, of, uf}
//   stat_total, stat_special   delivered / special result counts (FP_DIV_STATS_EN only)
module fp_div_frontend
  import fp_div_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  input  logic [31:0]      div_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
`ifdef FP_DIV_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_total,
  output logic [CNT_W-1:0] stat_special
`endif
);

  // Flush and classify the incoming operands.
  logic [31:0] a_ftz, b_ftz;
  logic [1:0]  a_cls_raw, b_cls_raw;

  fp_div_classify u_cls_a (.op(in_a), .op_ftz(a_ftz), .cls(a_cls_raw));
  fp_div_classify u_cls_b (.op(in_b), .op_ftz(b_ftz), .cls(b_cls_raw));

  // Handshake. Stage 2 frees up when empty or draining; stage 1 frees up
  // when empty or able to move into stage 2 on the same edge.
  logic v1, v2;
  logic ready2, accept, advance;

  assign ready2    = !v2 || out_ready;
  assign in_ready  = !v1 || ready2;
  assign accept    = in_valid && in_ready;
  assign advance   = v1 && ready2;
  assign out_valid = v2;

  // Stage-1 side state (div_a/div_b are the operand registers themselves).
  logic [TAG_W-1:0]  tag1;
  fp_cls_e           cls_a1, cls_b1;
  logic signed [9:0] e1;

  // Stage-2 result selection from stage-1 registers.
  logic        s2_sign;
  logic [31:0] q_n;
  logic [3:0]  flags_n;
  logic        sp_n;

  always_comb begin
    s2_sign = div_a[31] ^ div_b[31];
    q_n     = div_q;
    flags_n = 4'b0000;
    sp_n    = 1'b1;
    if (cls_a1 == CLS_NAN || cls_b1 == CLS_NAN ||
        (cls_a1 == CLS_ZERO && cls_b1 == CLS_ZERO) ||
        (cls_a1 == CLS_INF  && cls_b1 == CLS_INF)) begin
      q_n               = FP_QNAN;
      flags_n[FLAG_INV] = 1'b1;
    end else if (cls_a1 == CLS_NORM && cls_b1 == CLS_ZERO) begin
      q_n              = {s2_sign, FP_PINF[30:0]};
      flags_n[FLAG_DZ] = 1'b1;
    end else if (cls_a1 == CLS_INF) begin
      // Divisor is finite here (norm or zero); inf/0 raises no flag.
      q_n = {s2_sign, FP_PINF[30:0]};
    end else if (cls_b1 == CLS_INF || cls_a1 == CLS_ZERO) begin
      q_n = {s2_sign, 31'b0};
    end else if (e1 >= 10'sd255) begin
      q_n              = {s2_sign, FP_PINF[30:0]};
      flags_n[FLAG_OF] = 1'b1;
    end else if (e1 <= 10'sd0) begin
      q_n              = {s2_sign, 31'b0};
      flags_n[FLAG_UF] = 1'b1;
    end else begin
      sp_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      div_a     <= 32'd0;
      div_b     <= 32'd0;
      tag1      <= '0;
      cls_a1    <= CLS_ZERO;
      cls_b1    <= CLS_ZERO;
      e1        <= 10'sd0;
      out_q     <= 32'd0;
      out_tag   <= '0;
      out_flags <= 4'b0000;
    end else begin
      if (accept) begin
        v1     <= 1'b1;
        div_a  <= a_ftz;
        div_b  <= b_ftz;
        tag1   <= in_tag;
        cls_a1 <= fp_cls_e'(a_cls_raw);
        cls_b1 <= fp_cls_e'(b_cls_raw);
        e1     <= pred_exp(a_ftz, b_ftz);
      end else if (advance) begin
        v1 <= 1'b0;
      end

      if (advance) begin
        v2        <= 1'b1;
        out_q     <= q_n;
        out_tag   <= tag1;
        out_flags <= flags_n;
      end else if (out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

`ifdef FP_DIV_STATS_EN
  logic out_special;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_special  <= 1'b0;
      stat_total   <= '0;
      stat_special <= '0;
    end else begin
      if (advance) begin
        out_special <= sp_n;
      end
      if (v2 && out_ready) begin
        if (stat_total != '1) begin
          stat_total <= stat_total + CNT_W'(1);
        end
        if (out_special && stat_special != '1) begin
          stat_special <= stat_special + CNT_W'(1);
        end
      end
    end
  end
`else
  // Without statistics the special-result indication and CNT_W have no load.
  logic [CNT_W-1:0] unused_stats;
  assign unused_stats = {CNT_W{sp_n}};
`endif

endmodule

// File: tb/tb_fp_div_frontend.sv
// tb/tb_fp_div_frontend.sv - directed table and sequence bench for fp_div_frontend
module tb_fp_div_frontend;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [7:0]  in_tag;
  logic [31:0] div_a, div_b, div_q;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic [7:0]  out_tag;
  logic [3:0]  out_flags;
`ifdef FP_DIV_STATS_EN
  logic [15:0] stat_total, stat_special;
`endif

  always #5 clk = ~clk;

  fp_div_frontend #(.TAG_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_a(div_a), .div_b(div_b), .div_q(div_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_tag(out_tag), .out_flags(out_flags)
`ifdef FP_DIV_STATS_EN
    , .stat_total(stat_total), .stat_special(stat_special)
`endif
  );

  // Stand-in divider: exact for 6/2, otherwise a fixed scramble so that
  // passing div_q through is distinguishable from any special result.
  function automatic logic [31:0] dq(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ftz(input logic [31:0] x);
    return (x[30:23] == 8'h00) ? {x[31], 31'b0} : x;
  endfunction

  assign div_q = dq(div_a, div_b);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  tag;
    logic [31:0] q;
    logic [3:0]  fl;
    logic        sp;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag,
                              input logic [31:0] q, input logic [3:0] fl, input logic sp);
    vec_t v;
    v.a = a; v.b = b; v.tag = tag; v.q = q; v.fl = fl; v.sp = sp;
    return v;
  endfunction

  localparam int NV = 18;
  vec_t vt[NV];
  int   n_sp;
  logic [31:0] bp_a[4];

  initial begin
    // {a, b, tag, expected q, expected {inv,dz,of,uf}, special}
    vt[0]  = mk(32'h40C00000, 32'h40000000, 8'h5A, 32'h40400000, 4'b0000, 1'b0);
    vt[1]  = mk(32'hBF800000, 32'h00000000, 8'h01, 32'hFF800000, 4'b0100, 1'b1);
    vt[2]  = mk(32'h00000000, 32'h00000000, 8'h02, 32'h7FC00000, 4'b1000, 1'b1);
    vt[3]  = mk(32'h7F000000, 32'h3E800000, 8'h03, 32'h7F800000, 4'b0010, 1'b1);
    vt[4]  = mk(32'h00800000, 32'h4B000000, 8'h04, 32'h00000000, 4'b0001, 1'b1);
    vt[5]  = mk(32'h00000001, 32'h3F800000, 8'h05, 32'h00000000, 4'b0000, 1'b1);
    vt[6]  = mk(32'h7FC00001, 32'h3F800000, 8'h06, 32'h7FC00000, 4'b1000, 1'b1);
    vt[7]  = mk(32'hFF800000, 32'h7F800000, 8'h07, 32'h7FC00000, 4'b1000, 1'b1);
    vt[8]  = mk(32'hFF800000, 32'h40000000, 8'h08, 32'hFF800000, 4'b0000, 1'b1);
    vt[9]  = mk(32'h3F800000, 32'hFF800000, 8'h09, 32'h80000000, 4'b0000, 1'b1);
    vt[10] = mk(32'h80000000, 32'h40400000, 8'h0A, 32'h80000000, 4'b0000, 1'b1);
    vt[11] = mk(32'h7F800000, 32'h80000000, 8'h0B, 32'hFF800000, 4'b0000, 1'b1);
    vt[12] = mk(32'h3F800000, 32'h80000001, 8'h0C, 32'hFF800000, 4'b0100, 1'b1);
    vt[13] = mk(32'h3FC00000, 32'h3F000000, 8'h0D, dq(32'h3FC00000, 32'h3F000000), 4'b0000, 1'b0);
    vt[14] = mk(32'h7F000000, 32'h3F000000, 8'h0E, 32'h7F800000, 4'b0010, 1'b1);
    vt[15] = mk(32'h7F000000, 32'h3F800000, 8'h0F, dq(32'h7F000000, 32'h3F800000), 4'b0000, 1'b0);
    vt[16] = mk(32'h00800000, 32'h40000000, 8'h10, 32'h00000000, 4'b0001, 1'b1);
    vt[17] = mk(32'h00800000, 32'h3FC00000, 8'h11, 32'h00000000, 4'b0001, 1'b1);
    n_sp = 0;
    for (int i = 0; i < NV; i++) n_sp += int'(vt[i].sp);

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_q", out_q, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
`ifdef FP_DIV_STATS_EN
    chk("rst_stat_total", 32'(stat_total), 32'd0);
    chk("rst_stat_special", 32'(stat_special), 32'd0);
`endif

    // Table: one operand pair at a time, checked at stage 1 and stage 2
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = vt[i].a; in_b = vt[i].b; in_tag = vt[i].tag;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_div_a", i), div_a, ftz(vt[i].a));
      chk($sformatf("v%0d_div_b", i), div_b, ftz(vt[i].b));
      chk($sformatf("v%0d_early_valid", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_out_q", i), out_q, vt[i].q);
      chk($sformatf("v%0d_out_tag", i), 32'(out_tag), 32'(vt[i].tag));
      chk($sformatf("v%0d_out_flags", i), 32'(out_flags), 32'(vt[i].fl));
    end
    @(negedge clk);
    chk("table_drained", 32'(out_valid), 32'd0);
`ifdef FP_DIV_STATS_EN
    chk("table_stat_total", 32'(stat_total), 32'(NV));
    chk("table_stat_special", 32'(stat_special), 32'(n_sp));
`endif

    // Backpressure: out_ready low for 3 cycles while 4 inputs are offered
    begin
      int idx, got;
      logic acc, dup;
      for (int k = 0; k < 4; k++) bp_a[k] = 32'h40C00000 + 32'(k + 1);
      idx = 0; got = 0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        @(negedge clk);
        out_ready = (cyc >= 3);
        in_valid  = (idx < 4);
        in_a      = bp_a[idx % 4];
        in_b      = 32'h40000000;
        in_tag    = 8'hA0 + 8'(idx);
        #1;
        if (cyc == 2) begin
          chk("bp_in_ready_low", 32'(in_ready), 32'd0);
          chk("bp_stall_valid", 32'(out_valid), 32'd1);
          chk("bp_stall_tag", 32'(out_tag), 32'hA0);
        end
        if (cyc == 3) chk("bp_accepts_before_release", 32'(idx), 32'd2);
        if (out_valid && out_ready) begin
          chk($sformatf("bp_tag%0d", got), 32'(out_tag), 32'hA0 + 32'(got));
          chk($sformatf("bp_q%0d", got), out_q, dq(bp_a[got], 32'h40000000));
          got++;
        end
        acc = in_valid && in_ready;
        @(posedge clk);
        if (acc) idx++;
      end
      chk("bp_result_count", 32'(got), 32'd4);
      dup = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) begin
        #1;
        if (out_valid) dup = 1'b1;
        @(negedge clk);
      end
      chk("bp_no_duplicates", 32'(dup), 32'd0);
    end

    // Reset with both stages full
    begin
      logic stale;
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'h40C00000; in_b = 32'h40000000; in_tag = 8'hB0 + 8'(k);
        @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("mid_full_valid", 32'(out_valid), 32'd1);
      chk("mid_full_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_out_q", out_q, 32'd0);
`ifdef FP_DIV_STATS_EN
      chk("mid_rst_stat_total", 32'(stat_total), 32'd0);
      chk("mid_rst_stat_special", 32'(stat_special), 32'd0);
`endif
      stale = 1'b0;
      repeat (4) begin
        @(negedge clk);
        #1;
        if (out_valid) stale = 1'b1;
      end
      chk("mid_rst_no_stale", 32'(stale), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
